// File: rtl/decode_stage.sv
// ----------------------------------------------------------------------------
// decode_stage
//
// RV32I instruction-decode stage sitting directly behind fetch. Every cycle it
// splits the fetched instruction into its fields, builds the sign-extended
// immediate and registers the result into the ID/EX pipeline register. It also
// spots load-use hazards against the instruction in EX and, when one exists,
// inserts a single bubble while asking the PC logic to re-present the same PC.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   ir, pc1        fetched instruction and its address
//   stall_in       downstream stall, holds every registered output
//   flush          taken branch/jump in EX, kills the instruction in decode
//   ex_rd          destination register of the instruction in EX
//   ex_mem_read    instruction in EX is a load
//   load_use_stall combinational hazard request to the PC logic
//   id_*           registered ID/EX outputs (valid, pc, raw ir, fields,
//                  immediate, register write enable, illegal flag)
// ----------------------------------------------------------------------------
module decode_stage #(
   parameter logic [31:0] RESET_PC = 32'h00008000,
   parameter logic [31:0] NOP_INSN = 32'h00000013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ir,
   input  logic [31:0] pc1,
   input  logic        stall_in,
   input  logic        flush,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   output logic        load_use_stall,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_ir,
   output logic [6:0]  id_opcode,
   output logic [4:0]  id_rd,
   output logic [2:0]  id_funct3,
   output logic [4:0]  id_rs1,
   output logic [4:0]  id_rs2,
   output logic [6:0]  id_funct7,
   output logic [31:0] id_imm,
   output logic        id_rd_we,
   output logic        id_illegal
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm;
   logic        writes_rd;
   logic        uses_rs1;
   logic        uses_rs2;
   logic        illegal;

   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];

   // Opcode classification: immediate format, register usage and legality.
   always_comb begin
      imm       = 32'h0;
      writes_rd = 1'b0;
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      illegal   = 1'b0;
      case (opcode)
         OPC_LUI, OPC_AUIPC: begin
            imm       = {ir[31:12], 12'b0};
            writes_rd = 1'b1;
         end
         OPC_JAL: begin
            imm       = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            writes_rd = 1'b1;
         end
         OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_SYSTEM: begin
            imm       = {{20{ir[31]}}, ir[31:20]};
            writes_rd = 1'b1;
            uses_rs1  = 1'b1;
         end
         OPC_STORE: begin
            imm      = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         OPC_BRANCH: begin
            imm      = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         OPC_OP: begin
            writes_rd = 1'b1;
            uses_rs1  = 1'b1;
            uses_rs2  = 1'b1;
         end
         OPC_FENCE: begin
            imm = 32'h0;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

   // A flush already kills the decode slot, so a hazard against it is moot
   // and must not make the PC logic replay the killed instruction.
   assign load_use_stall = ex_mem_read && (ex_rd != 5'd0) && !flush &&
                           ((uses_rs1 && (rs1 == ex_rd)) ||
                            (uses_rs2 && (rs2 == ex_rd)));

   // ID/EX register. Flush beats stall so a killed instruction can never be
   // held in the slot and later released into EX. Bubbles clear the decoded
   // fields so nothing stale is visible downstream.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         id_valid   <= 1'b0;
         id_pc      <= RESET_PC;
         id_ir      <= NOP_INSN;
         id_opcode  <= 7'h0;
         id_rd      <= 5'h0;
         id_funct3  <= 3'h0;
         id_rs1     <= 5'h0;
         id_rs2     <= 5'h0;
         id_funct7  <= 7'h0;
         id_imm     <= 32'h0;
         id_rd_we   <= 1'b0;
         id_illegal <= 1'b0;
      end else if (flush || (!stall_in && load_use_stall)) begin
         id_valid   <= 1'b0;
         id_pc      <= pc1;
         id_ir      <= NOP_INSN;
         id_opcode  <= 7'h0;
         id_rd      <= 5'h0;
         id_funct3  <= 3'h0;
         id_rs1     <= 5'h0;
         id_rs2     <= 5'h0;
         id_funct7  <= 7'h0;
         id_imm     <= 32'h0;
         id_rd_we   <= 1'b0;
         id_illegal <= 1'b0;
      end else if (!stall_in) begin
         id_valid   <= 1'b1;
         id_pc      <= pc1;
         id_ir      <= ir;
         id_opcode  <= opcode;
         id_rd      <= rd;
         id_funct3  <= ir[14:12];
         id_rs1     <= rs1;
         id_rs2     <= rs2;
         id_funct7  <= ir[31:25];
         id_imm     <= imm;
         id_rd_we   <= writes_rd && (rd != 5'd0);
         id_illegal <= illegal;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_decode_stage
//
// Self-checking bench for decode_stage. A behavioural model classifies each
// opcode into its instruction format and computes the immediate with plain
// signed arithmetic; a registered copy of the expected ID/EX contents is
// updated on every clock and compared against the DUT on each falling edge.
// Directed scenarios carry hand-computed literal expectations as well.
// ----------------------------------------------------------------------------
module tb_decode_stage;

   logic        clk;
   logic        reset;
   logic [31:0] ir;
   logic [31:0] pc1;
   logic        stall_in;
   logic        flush;
   logic [4:0]  ex_rd;
   logic        ex_mem_read;
   logic        load_use_stall;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_ir;
   logic [6:0]  id_opcode;
   logic [4:0]  id_rd;
   logic [2:0]  id_funct3;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [6:0]  id_funct7;
   logic [31:0] id_imm;
   logic        id_rd_we;
   logic        id_illegal;

   int nCompared;
   int nMismatched;

   decode_stage dut (
      .clk            (clk),
      .reset          (reset),
      .ir             (ir),
      .pc1            (pc1),
      .stall_in       (stall_in),
      .flush          (flush),
      .ex_rd          (ex_rd),
      .ex_mem_read    (ex_mem_read),
      .load_use_stall (load_use_stall),
      .id_valid       (id_valid),
      .id_pc          (id_pc),
      .id_ir          (id_ir),
      .id_opcode      (id_opcode),
      .id_rd          (id_rd),
      .id_funct3      (id_funct3),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_funct7      (id_funct7),
      .id_imm         (id_imm),
      .id_rd_we       (id_rd_we),
      .id_illegal     (id_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural decode: format letter per opcode, then the immediate as
   // arithmetic on the signed instruction word.
   typedef struct {
      logic [31:0] imm;
      bit          wr;
      bit          u1;
      bit          u2;
      bit          ill;
   } dec_t;

   function automatic dec_t modelDecode(logic [31:0] insn);
      dec_t d;
      byte  fmt;
      int   s;
      s = int'(insn);
      case (insn[6:0])
         7'h37, 7'h17:               fmt = "U";
         7'h6F:                      fmt = "J";
         7'h67, 7'h03, 7'h13, 7'h73: fmt = "I";
         7'h23:                      fmt = "S";
         7'h63:                      fmt = "B";
         7'h33:                      fmt = "R";
         7'h0F:                      fmt = "F";
         default:                    fmt = "X";
      endcase
      d.ill = (fmt == "X");
      d.u1  = (fmt == "I" || fmt == "S" || fmt == "B" || fmt == "R");
      d.u2  = (fmt == "S" || fmt == "B" || fmt == "R");
      d.wr  = (fmt == "U" || fmt == "J" || fmt == "I" || fmt == "R") && (insn[11:7] != 5'd0);
      case (fmt)
         "U":     d.imm = insn & 32'hFFFFF000;
         "I":     d.imm = 32'(s >>> 20);
         "S":     d.imm = 32'((s >>> 25) << 5) | 32'(insn[11:7]);
         "B":     d.imm = 32'((s >>> 31) << 12) | (32'(insn[7]) << 11) |
                          (32'(insn[30:25]) << 5) | (32'(insn[11:8]) << 1);
         "J":     d.imm = 32'((s >>> 31) << 20) | (32'(insn[19:12]) << 12) |
                          (32'(insn[20]) << 11) | (32'(insn[30:21]) << 1);
         default: d.imm = 32'h0;
      endcase
      return d;
   endfunction

   function automatic bit modelHazard();
      dec_t d;
      d = modelDecode(ir);
      return ex_mem_read && (ex_rd != 5'd0) && !flush &&
             ((d.u1 && ir[19:15] == ex_rd) || (d.u2 && ir[24:20] == ex_rd));
   endfunction

   // Expected ID/EX contents. fieldsKnown marks whether the decoded fields
   // carry a defined value (after reset or a real load).
   bit          expValid;
   logic [31:0] expPc;
   logic [31:0] expIr;
   logic [31:0] expImm;
   bit          expRdWe;
   bit          expIll;
   bit          fieldsKnown;

   // Model of the ID/EX register, updated alongside the DUT.
   always @(posedge clk or negedge reset) begin
      dec_t d;
      if (!reset) begin
         expValid    <= 1'b0;
         expPc       <= 32'h00008000;
         expIr       <= 32'h00000013;
         expImm      <= 32'h0;
         expRdWe     <= 1'b0;
         expIll      <= 1'b0;
         fieldsKnown <= 1'b1;
      end else if (flush || (!stall_in && modelHazard())) begin
         expValid    <= 1'b0;
         expPc       <= pc1;
         expIr       <= 32'h00000013;
         expRdWe     <= 1'b0;
         expIll      <= 1'b0;
         fieldsKnown <= 1'b0;
      end else if (!stall_in) begin
         d = modelDecode(ir);
         expValid    <= 1'b1;
         expPc       <= pc1;
         expIr       <= ir;
         expImm      <= d.imm;
         expRdWe     <= d.wr;
         expIll      <= d.ill;
         fieldsKnown <= 1'b1;
      end
   end

   task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every registered output against the model.
   task automatic checkOutput();
      checkEq("id_valid", 32'(id_valid), 32'(expValid));
      checkEq("id_pc", id_pc, expPc);
      checkEq("id_ir", id_ir, expIr);
      checkEq("id_rd_we", 32'(id_rd_we), 32'(expRdWe));
      checkEq("id_illegal", 32'(id_illegal), 32'(expIll));
      if (fieldsKnown && expValid) begin
         checkEq("id_imm", id_imm, expImm);
         checkEq("id_opcode", 32'(id_opcode), 32'(expIr[6:0]));
         checkEq("id_rd", 32'(id_rd), 32'(expIr[11:7]));
         checkEq("id_funct3", 32'(id_funct3), 32'(expIr[14:12]));
         checkEq("id_rs1", 32'(id_rs1), 32'(expIr[19:15]));
         checkEq("id_rs2", 32'(id_rs2), 32'(expIr[24:20]));
         checkEq("id_funct7", 32'(id_funct7), 32'(expIr[31:25]));
      end else if (fieldsKnown) begin
         checkEq("id_imm_reset", id_imm, 32'h0);
         checkEq("id_fields_reset",
                 32'({id_opcode, id_rd, id_funct3, id_rs1, id_rs2, id_funct7}), 32'h0);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] i, input logic [31:0] p, input logic st,
                                input logic fl, input logic [4:0] erd, input logic emr);
      ir          = i;
      pc1         = p;
      stall_in    = st;
      flush       = fl;
      ex_rd       = erd;
      ex_mem_read = emr;
   endtask

   // Drive one cycle: check the combinational hazard output, then the
   // registered outputs after the next rising edge.
   task automatic stepCycle(input logic [31:0] i, input logic [31:0] p, input logic st,
                            input logic fl, input logic [4:0] erd, input logic emr);
      applyStimulus(i, p, st, fl, erd, emr);
      #1;
      checkEq("load_use_stall", 32'(load_use_stall), 32'(modelHazard()));
      @(negedge clk);
      checkOutput();
   endtask

   function automatic logic [31:0] randomInsn();
      logic [6:0]  opcs [10];
      logic [31:0] w;
      opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h73, 7'h23, 7'h63, 7'h33};
      w = $urandom;
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      w[11:7]  = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
         0:       w[6:0] = 7'h0F;
         1:       w[6:0] = 7'($urandom);
         default: w[6:0] = opcs[$urandom_range(0, 9)];
      endcase
      return w;
   endfunction

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      reset = 1'b1;
      applyStimulus(32'h00500093, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
      #1 reset = 1'b0;

      // Reset held with random instructions and a running clock.
      for (int k = 0; k < 3; k++) begin
         ir = $urandom;
         @(negedge clk);
         checkOutput();
         checkEq("reset_pc", id_pc, 32'h00008000);
         checkEq("reset_ir", id_ir, 32'h00000013);
      end

      // Release reset: the first edge decodes addi x1,x0,5.
      reset = 1'b1;
      stepCycle(32'h00500093, 32'h00000100, 1'b0, 1'b0, 5'd0, 1'b0);
      checkEq("addi_valid", 32'(id_valid), 32'd1);
      checkEq("addi_rd", 32'(id_rd), 32'd1);
      checkEq("addi_rs1", 32'(id_rs1), 32'd0);
      checkEq("addi_imm", id_imm, 32'd5);
      checkEq("addi_rd_we", 32'(id_rd_we), 32'd1);

      // Downstream stall for three cycles holds everything.
      for (int k = 0; k < 3; k++) begin
         stepCycle(32'h123452B7, 32'h00000200 + 32'(k), 1'b1, 1'b0, 5'd0, 1'b0);
         checkEq("stall_hold_ir", id_ir, 32'h00500093);
         checkEq("stall_hold_pc", id_pc, 32'h00000100);
         checkEq("stall_hold_imm", id_imm, 32'd5);
      end

      stepCycle(32'h123452B7, 32'h00000104, 1'b0, 1'b0, 5'd0, 1'b0);
      checkEq("lui_imm", id_imm, 32'h12345000);
      checkEq("lui_rd", 32'(id_rd), 32'd5);

      stepCycle(32'hFE20AE23, 32'h00000108, 1'b0, 1'b0, 5'd0, 1'b0);
      checkEq("sw_imm", id_imm, 32'hFFFFFFFC);
      checkEq("sw_rs1", 32'(id_rs1), 32'd1);
      checkEq("sw_rs2", 32'(id_rs2), 32'd2);
      checkEq("sw_rd_we", 32'(id_rd_we), 32'd0);

      stepCycle(32'hFE209CE3, 32'h0000010C, 1'b0, 1'b0, 5'd0, 1'b0);
      checkEq("bne_imm", id_imm, 32'hFFFFFFF8);
      checkEq("bne_rd_we", 32'(id_rd_we), 32'd0);

      // Load-use hazard on add x3,x1,x2 with x1 being loaded.
      applyStimulus(32'h002081B3, 32'h00000110, 1'b0, 1'b0, 5'd1, 1'b1);
      #1 checkEq("lu_stall", 32'(load_use_stall), 32'd1);
      @(negedge clk);
      checkOutput();
      checkEq("lu_bubble", 32'(id_valid), 32'd0);
      checkEq("lu_bubble_pc", id_pc, 32'h00000110);

      applyStimulus(32'h002081B3, 32'h00000110, 1'b0, 1'b0, 5'd0, 1'b1);
      #1 checkEq("lu_x0_stall", 32'(load_use_stall), 32'd0);
      @(negedge clk);
      checkOutput();
      checkEq("lu_x0_valid", 32'(id_valid), 32'd1);

      applyStimulus(32'h001002B7, 32'h00000114, 1'b0, 1'b0, 5'd1, 1'b1);
      #1 checkEq("lu_lui_stall", 32'(load_use_stall), 32'd0);
      @(negedge clk);
      checkOutput();

      // Flush + stall + hazard: flush wins, bubble loaded.
      applyStimulus(32'h002081B3, 32'h00000118, 1'b1, 1'b1, 5'd1, 1'b1);
      #1 checkEq("flush_stall", 32'(load_use_stall), 32'd0);
      @(negedge clk);
      checkOutput();
      checkEq("flush_valid", 32'(id_valid), 32'd0);
      checkEq("flush_ir", id_ir, 32'h00000013);
      checkEq("flush_pc", id_pc, 32'h00000118);

      stepCycle(32'h0000007F, 32'h0000011C, 1'b0, 1'b0, 5'd0, 1'b0);
      checkEq("ill_flag", 32'(id_illegal), 32'd1);
      checkEq("ill_rd_we", 32'(id_rd_we), 32'd0);

      stepCycle(32'h00500013, 32'h00000120, 1'b0, 1'b0, 5'd0, 1'b0);
      checkEq("x0_rd_we", 32'(id_rd_we), 32'd0);
      checkEq("x0_illegal", 32'(id_illegal), 32'd0);

      // Randomized traffic with an asynchronous reset mid-stream.
      for (int n = 0; n < 600; n++) begin
         if (n == 300) begin
            applyStimulus(randomInsn(), 32'h00000400, 1'b0, 1'b0, 5'd0, 1'b0);
            #2 reset = 1'b0;
            #1;
            checkEq("async_valid", 32'(id_valid), 32'd0);
            checkEq("async_pc", id_pc, 32'h00008000);
            checkEq("async_ir", id_ir, 32'h00000013);
            checkOutput();
            @(negedge clk);
            checkOutput();
            reset = 1'b1;
         end
         stepCycle(randomInsn(), {$urandom_range(0, 16'hFFFF), 2'b00} + 32'h1000,
                   1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 10),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
